// File: rtl/seq_detector_1101.sv
// seq_detector_1101: Moore FSM detecting overlapping serial 1101, with a saturating match counter
//   clk, rst (async, active-high), in/in_valid (serial bit + qualifier), clear_count (sync counter clear)
//   detect (registered, high while in S4), current/next (state and next state), match_count (saturating)
module seq_detector_1101 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clear_count,
  output logic             detect,
  output logic [2:0]       current,
  output logic [2:0]       next,
  output logic [CNT_W-1:0] match_count
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;
  state_t cur, nxt;
  always_comb begin
    nxt = S0;
    case (cur)
      S0:      nxt = in_valid ? (in ? S1 : S0) : S0;
      S1:      nxt = in_valid ? (in ? S2 : S0) : S1;
      S2:      nxt = in_valid ? (in ? S2 : S3) : S2;
      S3:      nxt = in_valid ? (in ? S4 : S0) : S3;
      S4:      nxt = in_valid ? (in ? S2 : S0) : S4;
      default: nxt = S0;
    endcase
  end
  // detect is a flop loaded with the S4 decode of next, so it tracks current==S4 glitch-free
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur         <= S0;
      detect      <= 1'b0;
      match_count <= '0;
    end else begin
      cur         <= nxt;
      detect      <= nxt == S4;
      match_count <= clear_count ? '0 :
                     (in_valid && nxt == S4 && match_count != '1) ? match_count + 1'b1 : match_count;
    end
  assign current = cur;
  assign next    = nxt;
endmodule

// File: tb/tb_seq_detector_1101.sv
// tb_seq_detector_1101: random and directed checks of seq_detector_1101 against a history-based model
module tb_seq_detector_1101;
  logic clk = 0, rst = 1, in = 0, in_valid = 0, clear_count = 0;
  logic det_a, det_b;
  logic [2:0] cur_a, nxt_a, cur_b, nxt_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  seq_detector_1101 #(.CNT_W(8)) dut_a (.clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
    .clear_count(clear_count), .detect(det_a), .current(cur_a), .next(nxt_a), .match_count(cnt_a));
  seq_detector_1101 #(.CNT_W(2)) dut_b (.clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
    .clear_count(clear_count), .detect(det_b), .current(cur_b), .next(nxt_b), .match_count(cnt_b));
  // model: last four accepted bits (hist[0] newest), how many were accepted since reset, match counts
  logic [3:0] hist;
  int n, mcnt_a, mcnt_b;
  // progress = longest suffix of accepted bits that is a prefix of 1,1,0,1
  function automatic int prog(input logic [3:0] h, input int len);
    logic [3:0] p;
    bit ok;
    p = 4'b1011;
    for (int k = 4; k > 0; k--) begin
      ok = len >= k;
      for (int j = 0; j < k; j++) if (h[k-1-j] != p[j]) ok = 0;
      if (ok) return k;
    end
    return 0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge rst) begin
    bit hit;
    if (rst) begin
      hist = 0; n = 0; mcnt_a = 0; mcnt_b = 0;
    end else begin
      hit = 0;
      if (in_valid) begin
        hist = {hist[2:0], in};
        n = n < 4 ? n + 1 : 4;
        hit = prog(hist, n) == 4;
      end
      if (clear_count) begin
        mcnt_a = 0; mcnt_b = 0;
      end else if (hit) begin
        if (mcnt_a < 255) mcnt_a++;
        if (mcnt_b < 3) mcnt_b++;
      end
    end
  end
  always @(negedge clk) begin
    int s, sn;
    s  = prog(hist, n);
    sn = in_valid ? prog({hist[2:0], in}, n < 4 ? n + 1 : 4) : s;
    chk("current_a", cur_a, s);
    chk("current_b", cur_b, s);
    chk("next_a", nxt_a, sn);
    chk("next_b", nxt_b, sn);
    chk("detect_a", det_a, s == 4);
    chk("detect_b", det_b, s == 4);
    chk("count_a", cnt_a, mcnt_a);
    chk("count_b", cnt_b, mcnt_b);
    chk("known", $isunknown({det_a, det_b, cur_a, cur_b, nxt_a, nxt_b, cnt_a, cnt_b}), 0);
    chk("legal", cur_a <= 4 && cur_b <= 4, 1);
  end
  task automatic step(input logic b, input logic v, input logic c);
    @(posedge clk);
    #1;
    in = b; in_valid = v; clear_count = c;
  endtask
  task automatic bits(input logic [15:0] pat, input int len);
    for (int i = len - 1; i >= 0; i--) step(pat[i], 1, 0);
    step(0, 0, 0);
  endtask
  task automatic async_rst();
    in_valid = 0; clear_count = 0;
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_current", cur_a, 0);
    chk("arst_detect", det_a, 0);
    chk("arst_count", cnt_a, 0);
    #1 rst = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_current", cur_a, 0);
    chk("reset_detect", det_a, 0);
    chk("reset_count", cnt_a, 0);
    rst = 0;
    bits(16'b1101, 4);
    chk("basic_current", cur_a, 4);
    chk("basic_detect", det_a, 1);
    chk("basic_count", cnt_a, 1);
    async_rst();
    bits(16'b1101101, 7);
    chk("overlap_current", cur_a, 4);
    chk("overlap_count", cnt_a, 2);
    async_rst();
    step(1, 1, 0); step(1, 1, 0);
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    chk("stall_current", cur_a, 2);
    bits(16'b01, 2);
    chk("stall_detect", det_a, 1);
    chk("stall_count", cnt_a, 1);
    async_rst();
    bits(16'b1101101101101, 13);
    chk("sat_count_b", cnt_b, 3);
    chk("sat_count_a", cnt_a, 4);
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 1); step(0, 0, 0);
    chk("clear_count_b", cnt_b, 0);
    chk("clear_count_a", cnt_a, 0);
    chk("clear_detect", det_b, 1);
    async_rst();
    bits(16'b110, 3);
    chk("mid_current", cur_a, 3);
    async_rst();
    bits(16'b1, 1);
    chk("post_rst_current", cur_a, 1);
    chk("post_rst_detect", det_a, 0);
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    step(0, 0, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
